// File: rtl/seq_compare_array.sv
// Multi-cycle magnitude/equality comparator: walks CHUNK-bit slices from the MSB end,
// stopping at the first slice that differs, with a start/busy/done handshake.
module seq_compare_array #(
  parameter int WIDTH = 24,
  parameter int CHUNK = 6,
  localparam int NSLICE = WIDTH / CHUNK,
  localparam int CW = $clog2(NSLICE + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_mode,
  output logic             busy,
  output logic             done,
  output logic             equ,
  output logic             lt,
  output logic             gt,
  output logic [CW-1:0]    cycles
);

  localparam int IW = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] opA_q, opA_d;
  logic [WIDTH-1:0] opB_q, opB_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             equ_q, equ_d;
  logic             lt_q, lt_d;
  logic             gt_q, gt_d;
  logic [CW-1:0]    cycles_q, cycles_d;

  logic [WIDTH-1:0] signFlip;
  logic [CHUNK-1:0] sliceA, sliceB;
  logic [CW-1:0]    cntInc;

  // Inverting the sign bit of both operands turns a signed compare into an
  // unsigned one; only the top slice is affected, so it is done once at capture.
  assign signFlip = {signed_mode, {(WIDTH-1){1'b0}}};
  assign cntInc   = cnt_q + CW'(1);

  always_comb begin
    sliceA = opA_q[int'(idx_q) * CHUNK +: CHUNK];
    sliceB = opB_q[int'(idx_q) * CHUNK +: CHUNK];
  end

  always_comb begin
    state_d  = state_q;
    opA_d    = opA_q;
    opB_d    = opB_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    equ_d    = equ_q;
    lt_d     = lt_q;
    gt_d     = gt_q;
    cycles_d = cycles_q;

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          opA_d   = a ^ signFlip;
          opB_d   = b ^ signFlip;
          idx_d   = IW'(NSLICE - 1);
          cnt_d   = '0;
          state_d = CMP;
        end
      end

      CMP: begin
        cnt_d = cntInc;
        if (sliceA != sliceB) begin
          equ_d    = 1'b0;
          lt_d     = (sliceA < sliceB);
          gt_d     = (sliceA > sliceB);
          cycles_d = cntInc;
          state_d  = DONE;
        end else if (idx_q == '0) begin
          equ_d    = 1'b1;
          lt_d     = 1'b0;
          gt_d     = 1'b0;
          cycles_d = cntInc;
          state_d  = DONE;
        end else begin
          idx_d = idx_q - IW'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      opA_q    <= '0;
      opB_q    <= '0;
      idx_q    <= '0;
      cnt_q    <= '0;
      equ_q    <= 1'b0;
      lt_q     <= 1'b0;
      gt_q     <= 1'b0;
      cycles_q <= '0;
    end else begin
      state_q  <= state_d;
      opA_q    <= opA_d;
      opB_q    <= opB_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      equ_q    <= equ_d;
      lt_q     <= lt_d;
      gt_q     <= gt_d;
      cycles_q <= cycles_d;
    end
  end

  assign busy   = (state_q == CMP);
  assign done   = (state_q == DONE);
  assign equ    = equ_q;
  assign lt     = lt_q;
  assign gt     = gt_q;
  assign cycles = cycles_q;

endmodule
